// File: rtl/axi_wr_arb_pkg.sv
// Shared payload types and FSM state encoding for the 2:1 AXI write arbiter.
package axi_wr_arb_pkg;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 64;
  localparam int DATA_WIDTH = 128;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } aw_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
  } w_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [1:0]          resp;
  } b_t;

  // Downstream IDs carry the requester index as their extra top bit.
  typedef struct packed {
    logic [ID_WIDTH:0]     id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } maw_t;

  typedef struct packed {
    logic [ID_WIDTH:0] id;
    logic [1:0]        resp;
  } mb_t;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axi_wr_arb_idx_fifo.sv
// Grant-order FIFO: remembers which requester owns each outstanding W burst.
module axi_wr_arb_idx_fifo #(
  parameter int  DEPTH = 4,
  localparam int PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CntW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            data_i,
  input  logic            pop_i,
  output logic            data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic            mem_q [DEPTH];
  logic [PtrW-1:0] wrPtr_q;
  logic [PtrW-1:0] rdPtr_q;
  logic [CntW-1:0] count_q;
  logic            doPush;
  logic            doPop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= PtrW'(wrPtr_q + 1'b1);
      if (doPop)  rdPtr_q <= PtrW'(rdPtr_q + 1'b1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/axi_wr_arb_2x1.sv
// Two-requester AXI write arbiter; define AXI_WR_ARB_RR_EN for round-robin,
// otherwise requester 0 has fixed priority.
module axi_wr_arb_2x1
  import axi_wr_arb_pkg::*;
#(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 128,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  aw_t       [1:0] s_aw,
  input  logic      [1:0] s_awvalid,
  output logic      [1:0] s_awready,
  input  w_t        [1:0] s_w,
  input  logic      [1:0] s_wvalid,
  output logic      [1:0] s_wready,
  output b_t        [1:0] s_b,
  output logic      [1:0] s_bvalid,
  input  logic      [1:0] s_bready,
  output maw_t            m_aw,
  output logic            m_awvalid,
  input  logic            m_awready,
  output w_t              m_w,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  mb_t             m_b,
  input  logic            m_bvalid,
  output logic            m_bready
);

  localparam int CntW = $clog2(WFIFO_DEPTH) + 1;

  arb_state_e            state_q, state_d;
  maw_t                  mAw_q, mAw_d;
  logic                  winIdx;
  logic                  grant;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  headIdx;
  logic                  wActive;
  logic                  wPop;
  logic [CntW-1:0]       fifoCount;
  logic [ID_WIDTH-1:0]   winId;
  logic [ADDR_WIDTH-1:0] winAddr;
  logic [DATA_WIDTH-1:0] wData;
  logic                  bSel;
  logic [ID_WIDTH-1:0]   bId;

`ifdef AXI_WR_ARB_RR_EN
  logic rrPtr_q;

  // rrPtr_q names the requester that wins when both are asking.
  always_comb begin
    if (&s_awvalid) winIdx = rrPtr_q;
    else            winIdx = ~s_awvalid[0];
  end

  always_ff @(posedge clk) begin
    if (rst)        rrPtr_q <= 1'b0;
    else if (grant) rrPtr_q <= ~winIdx;
  end
`else
  assign winIdx = ~s_awvalid[0];
`endif

  // The full check deliberately uses the registered count, ignoring a same-cycle pop.
  assign grant     = !rst && (state_q == ARB) && (|s_awvalid) && !fifoFull;
  assign s_awready = grant ? (2'b01 << winIdx) : 2'b00;
  assign winId     = s_aw[winIdx].id;
  assign winAddr   = s_aw[winIdx].addr;

  always_comb begin
    state_d = state_q;
    mAw_d   = mAw_q;
    case (state_q)
      ARB: begin
        if (grant) begin
          mAw_d   = '{id: {winIdx, winId}, addr: winAddr, len: s_aw[winIdx].len,
                      size: s_aw[winIdx].size, burst: s_aw[winIdx].burst};
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_awready) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      mAw_q   <= '0;
    end else begin
      state_q <= state_d;
      mAw_q   <= mAw_d;
    end
  end

  assign m_awvalid = !rst && (state_q == ISSUE);
  assign m_aw      = rst ? '0 : mAw_q;

  axi_wr_arb_idx_fifo #(
    .DEPTH (WFIFO_DEPTH)
  ) u_idx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (grant),
    .data_i  (winIdx),
    .pop_i   (wPop),
    .data_o  (headIdx),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // W beats follow the oldest outstanding grant.
  assign wActive  = !rst && !fifoEmpty && (fifoCount != '0);
  assign wData    = s_w[headIdx].data;
  assign m_w      = '{data: wData, strb: s_w[headIdx].strb, last: s_w[headIdx].last};
  assign m_wvalid = wActive && s_wvalid[headIdx];
  assign s_wready = wActive ? ({1'b0, m_wready} << headIdx) : 2'b00;
  assign wPop     = m_wvalid && m_wready && m_w.last;

  assign bSel     = m_b.id[ID_WIDTH];
  assign bId      = m_b.id[ID_WIDTH-1:0];
  assign s_b[0]   = '{id: bId, resp: m_b.resp};
  assign s_b[1]   = '{id: bId, resp: m_b.resp};
  assign s_bvalid = {1'b0, m_bvalid} << bSel;
  assign m_bready = s_bready[bSel];

endmodule

// File: tb/tb_axi_wr_arb_2x1.sv
// Self-checking bench for axi_wr_arb_2x1: B-routing vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_axi_wr_arb_2x1;
  import axi_wr_arb_pkg::*;

  localparam int WFIFO_DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  aw_t       [1:0] s_aw;
  logic      [1:0] s_awvalid;
  logic      [1:0] s_awready;
  w_t        [1:0] s_w;
  logic      [1:0] s_wvalid;
  logic      [1:0] s_wready;
  b_t        [1:0] s_b;
  logic      [1:0] s_bvalid;
  logic      [1:0] s_bready;
  maw_t            m_aw;
  logic            m_awvalid;
  logic            m_awready;
  w_t              m_w;
  logic            m_wvalid;
  logic            m_wready;
  mb_t             m_b;
  logic            m_bvalid;
  logic            m_bready;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  axi_wr_arb_2x1 #(
    .ID_WIDTH    (4),
    .ADDR_WIDTH  (64),
    .DATA_WIDTH  (128),
    .WFIFO_DEPTH (WFIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_aw      (s_aw),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_w       (s_w),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_b       (s_b),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .m_aw      (m_aw),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_w       (m_w),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_b       (m_b),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready)
  );

  typedef struct {
    logic [4:0] bid;
    logic [1:0] resp;
    logic       bvalid;
    logic [1:0] bready;
    logic [1:0] expBvalid;
    logic       expSel;
    logic [3:0] expId;
    logic       expBready;
  } bVec_t;

  bVec_t bTab[6];

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idleInputs();
    s_aw      = '0;
    s_awvalid = 2'b00;
    s_w       = '0;
    s_wvalid  = 2'b00;
    s_bready  = 2'b00;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_b       = '0;
    m_bvalid  = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Random per-cycle drive of every upstream/downstream input.
  task automatic applyStimulus();
    for (int i = 0; i < 2; i++) begin
      s_aw[i].id    = 4'($urandom);
      s_aw[i].addr  = {$urandom, $urandom};
      s_aw[i].len   = 8'($urandom);
      s_aw[i].size  = 3'($urandom);
      s_aw[i].burst = 2'($urandom);
      s_w[i].data   = {$urandom, $urandom, $urandom, $urandom};
      s_w[i].strb   = 16'($urandom);
      s_w[i].last   = ($urandom_range(0, 2) == 0);
    end
    s_awvalid = 2'($urandom);
    s_wvalid  = 2'($urandom);
    m_awready = 1'($urandom);
    m_wready  = 1'($urandom);
  endtask

  // Reference model: a queue of granted requester indices plus the AW
  // currently offered downstream.
  task automatic randomPhase(input int cycles);
    bit   q[$];
    bit   busy    = 1'b0;
    bit   lastWin = 1'b1;
    bit   win;
    bit   h;
    bit   grantNow;
    bit   pop;
    maw_t expAw   = '0;
    for (int c = 0; c < cycles; c++) begin
      applyStimulus();
      #1;
      grantNow = !busy && (s_awvalid != 2'b00) && (q.size() < WFIFO_DEPTH);
      if (s_awvalid == 2'b11) begin
`ifdef AXI_WR_ARB_RR_EN
        win = !lastWin;
`else
        win = 1'b0;
`endif
      end else begin
        win = (s_awvalid == 2'b10);
      end
      checkOutput("rnd s_awready", s_awready, grantNow ? (2'b01 << win) : 2'b00);
      checkOutput("rnd m_awvalid", m_awvalid, busy);
      if (busy) checkOutput("rnd m_aw", m_aw, expAw);
      pop = 1'b0;
      if (q.size() > 0) begin
        h = q[0];
        checkOutput("rnd m_wvalid", m_wvalid, s_wvalid[h]);
        checkOutput("rnd s_wready", s_wready, m_wready ? (2'b01 << h) : 2'b00);
        checkOutput("rnd m_w", m_w, s_w[h]);
        pop = s_wvalid[h] && m_wready && s_w[h].last;
      end else begin
        checkOutput("rnd m_wvalid idle", m_wvalid, 1'b0);
        checkOutput("rnd s_wready idle", s_wready, 2'b00);
      end
      if (busy && m_awready) busy = 1'b0;
      if (pop) void'(q.pop_front());
      if (grantNow) begin
        q.push_back(win);
        busy    = 1'b1;
        lastWin = win;
        expAw   = '{id: {win, s_aw[win].id}, addr: s_aw[win].addr, len: s_aw[win].len,
                    size: s_aw[win].size, burst: s_aw[win].burst};
      end
      tick();
    end
  endtask

  initial begin
    bit   order[4];
    bit   expOrder[4];
    int   nGrant;
    maw_t expA;

    // B routing vectors: {m_b.id, resp, m_bvalid, s_bready} -> expected.
    bTab[0] = '{5'b1_0111, 2'd0, 1'b1, 2'b00, 2'b10, 1'b1, 4'h7, 1'b0};
    bTab[1] = '{5'b1_0111, 2'd0, 1'b1, 2'b10, 2'b10, 1'b1, 4'h7, 1'b1};
    bTab[2] = '{5'b0_1010, 2'd2, 1'b1, 2'b01, 2'b01, 1'b0, 4'hA, 1'b1};
    bTab[3] = '{5'b0_1010, 2'd2, 1'b1, 2'b10, 2'b01, 1'b0, 4'hA, 1'b0};
    bTab[4] = '{5'b1_1111, 2'd3, 1'b0, 2'b11, 2'b00, 1'b1, 4'hF, 1'b1};
    bTab[5] = '{5'b0_0000, 2'd1, 1'b1, 2'b11, 2'b01, 1'b0, 4'h0, 1'b1};

    // Reset state, with upstream requests present to show they are ignored.
    rst = 1'b1;
    idleInputs();
    s_awvalid = 2'b11;
    s_wvalid  = 2'b11;
    m_wready  = 1'b1;
    tick();
    #1;
    checkOutput("reset s_awready", s_awready, 2'b00);
    checkOutput("reset m_awvalid", m_awvalid, 1'b0);
    checkOutput("reset m_aw", m_aw, '0);
    checkOutput("reset m_wvalid", m_wvalid, 1'b0);
    checkOutput("reset s_wready", s_wready, 2'b00);
    tick();
    rst = 1'b0;
    idleInputs();

    for (int i = 0; i < 6; i++) begin
      m_b.id   = bTab[i].bid;
      m_b.resp = bTab[i].resp;
      m_bvalid = bTab[i].bvalid;
      s_bready = bTab[i].bready;
      #1;
      checkOutput("b s_bvalid", s_bvalid, bTab[i].expBvalid);
      checkOutput("b s_b.id", s_b[bTab[i].expSel].id, bTab[i].expId);
      checkOutput("b s_b.resp", s_b[bTab[i].expSel].resp, bTab[i].resp);
      checkOutput("b m_bready", m_bready, bTab[i].expBready);
    end
    idleInputs();

    // Single burst from requester 0: id 3, len 3.
    doReset();
    s_aw[0].id   = 4'd3;
    s_aw[0].len  = 8'd3;
    s_aw[0].addr = 64'h1000;
    s_awvalid    = 2'b01;
    m_awready    = 1'b1;
    #1;
    checkOutput("single s_awready", s_awready, 2'b01);
    tick();
    s_awvalid = 2'b00;
    #1;
    checkOutput("single m_awvalid", m_awvalid, 1'b1);
    checkOutput("single m_aw.id", m_aw.id, 5'b0_0011);
    checkOutput("single m_aw.len", m_aw.len, 8'd3);
    tick();
    m_wready       = 1'b1;
    s_wvalid       = 2'b11;
    s_w[1].data    = 128'hdead;
    for (int b = 0; b < 4; b++) begin
      s_w[0].data = 128'(32'h100 + b);
      s_w[0].last = (b == 3);
      #1;
      checkOutput("single m_wvalid", m_wvalid, 1'b1);
      checkOutput("single s_wready", s_wready, 2'b01);
      checkOutput("single m_w.data", m_w.data, 128'(32'h100 + b));
      tick();
    end
    #1;
    checkOutput("single popped m_wvalid", m_wvalid, 1'b0);
    checkOutput("single popped s_wready", s_wready, 2'b00);

    // Contention until the grant FIFO fills, then release one slot.
    doReset();
    s_aw[0].id = 4'd1;
    s_aw[1].id = 4'd2;
    s_awvalid  = 2'b11;
    m_awready  = 1'b1;
    nGrant     = 0;
    for (int c = 0; c < 20 && nGrant < 4; c++) begin
      #1;
      if (s_awready != 2'b00) begin
        order[nGrant] = s_awready[1];
        nGrant++;
      end
      tick();
    end
`ifdef AXI_WR_ARB_RR_EN
    expOrder = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    expOrder = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    checkOutput("contention grant count", 256'(nGrant), 256'd4);
    for (int i = 0; i < 4; i++) checkOutput("contention order", order[i], expOrder[i]);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("full s_awready", s_awready, 2'b00);
      tick();
    end
    s_wvalid    = 2'b01;
    s_w[0].last = 1'b1;
    m_wready    = 1'b1;
    #1;
    checkOutput("full pop m_wvalid", m_wvalid, 1'b1);
    checkOutput("full pop-cycle s_awready", s_awready, 2'b00);
    tick();
    s_wvalid = 2'b00;
    m_wready = 1'b0;
    #1;
    checkOutput("full after-pop s_awready", s_awready, 2'b01);
    tick();

    // AW backpressure: payload must hold for 5 stalled cycles.
    doReset();
    s_aw[0] = '{id: 4'hC, addr: 64'hABCD_0000_1234_5678, len: 8'd7, size: 3'd4, burst: 2'd1};
    expA    = '{id: 5'b0_1100, addr: 64'hABCD_0000_1234_5678, len: 8'd7, size: 3'd4, burst: 2'd1};
    s_awvalid = 2'b01;
    #1;
    checkOutput("bp s_awready", s_awready, 2'b01);
    tick();
    for (int c = 0; c < 5; c++) begin
      s_aw[0].addr = {$urandom, $urandom};
      s_aw[1].id   = 4'($urandom);
      s_awvalid    = 2'b11;
      #1;
      checkOutput("bp m_awvalid", m_awvalid, 1'b1);
      checkOutput("bp m_aw", m_aw, expA);
      checkOutput("bp s_awready", s_awready, 2'b00);
      tick();
    end
    s_awvalid = 2'b00;
    m_awready = 1'b1;
    tick();
    #1;
    checkOutput("bp released m_awvalid", m_awvalid, 1'b0);

    // Reset after two of four W beats.
    doReset();
    s_aw[0].id  = 4'd5;
    s_aw[0].len = 8'd3;
    s_awvalid   = 2'b01;
    m_awready   = 1'b1;
    tick();
    s_awvalid = 2'b00;
    s_wvalid  = 2'b01;
    m_wready  = 1'b1;
    tick();
    tick();
    rst       = 1'b1;
    s_wvalid  = 2'b11;
    s_awvalid = 2'b11;
    #1;
    checkOutput("midrst s_awready", s_awready, 2'b00);
    checkOutput("midrst m_wvalid", m_wvalid, 1'b0);
    checkOutput("midrst s_wready", s_wready, 2'b00);
    tick();
    rst       = 1'b0;
    s_awvalid = 2'b00;
    #1;
    checkOutput("postrst m_awvalid", m_awvalid, 1'b0);
    checkOutput("postrst m_wvalid", m_wvalid, 1'b0);
    checkOutput("postrst s_wready", s_wready, 2'b00);
    s_aw[1].id = 4'd9;
    s_awvalid  = 2'b10;
    #1;
    checkOutput("postrst s_awready", s_awready, 2'b10);
    tick();
    s_awvalid = 2'b00;
    s_wvalid  = 2'b10;
    #1;
    checkOutput("postrst m_awvalid", m_awvalid, 1'b1);
    checkOutput("postrst m_aw.id", m_aw.id, 5'b1_1001);
    checkOutput("postrst s_wready", s_wready, 2'b10);

    doReset();
    randomPhase(400);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
